// File: rtl/rs_branch_queue.sv
// Four-entry reservation station for the branch unit: holds micro-ops until
// both operands arrive, snoops two writeback buses, issues the lowest ready entry.
module rs_branch_queue #(
    parameter int DATA_LEN     = 32,
    parameter int ADDR_LEN     = 32,
    parameter int RRF_SEL      = 6,
    parameter int SPECTAG_LEN  = 5,
    parameter int ALU_OP_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [DATA_LEN-1:0]     src1,
    input  logic [DATA_LEN-1:0]     src2,
    input  logic                    valid1,
    input  logic                    valid2,
    input  logic [ADDR_LEN-1:0]     pc_in,
    input  logic [DATA_LEN-1:0]     imm_in,
    input  logic [ADDR_LEN-1:0]     praddr_in,
    input  logic [ALU_OP_WIDTH-1:0] alu_op_in,
    input  logic [6:0]              opcode_in,
    input  logic                    dstval_in,
    input  logic [SPECTAG_LEN-1:0]  spectag_in,
    input  logic                    specbit_in,
    input  logic                    wb_we_a,
    input  logic                    wb_we_b,
    input  logic [RRF_SEL-1:0]      wb_tag_a,
    input  logic [RRF_SEL-1:0]      wb_tag_b,
    input  logic [DATA_LEN-1:0]     wb_data_a,
    input  logic [DATA_LEN-1:0]     wb_data_b,
    input  logic                    prmiss,
    input  logic                    prsuccess,
    input  logic [SPECTAG_LEN-1:0]  spectagfix,
    input  logic [SPECTAG_LEN-1:0]  killmask,
    output logic                    issue,
    output logic [DATA_LEN-1:0]     ex_src1,
    output logic [DATA_LEN-1:0]     ex_src2,
    output logic [ADDR_LEN-1:0]     ex_pc,
    output logic [DATA_LEN-1:0]     ex_imm,
    output logic [ADDR_LEN-1:0]     ex_praddr,
    output logic [ALU_OP_WIDTH-1:0] ex_alu_op,
    output logic [6:0]              ex_opcode,
    output logic                    ex_dstval,
    output logic [SPECTAG_LEN-1:0]  ex_spectag,
    output logic                    ex_specbit,
    output logic                    full,
    output logic [3:0]              busyvec
);

    localparam int ENTRY_NUM = 4;
    localparam int IDX_W     = $clog2(ENTRY_NUM);

    typedef struct packed {
        logic                    busy;
        logic                    valid1;
        logic                    valid2;
        logic [DATA_LEN-1:0]     src1;
        logic [DATA_LEN-1:0]     src2;
        logic [ADDR_LEN-1:0]     pc;
        logic [DATA_LEN-1:0]     imm;
        logic [ADDR_LEN-1:0]     praddr;
        logic [ALU_OP_WIDTH-1:0] alu_op;
        logic [6:0]              opcode;
        logic                    dstval;
        logic [SPECTAG_LEN-1:0]  spectag;
        logic                    specbit;
    } entry_t;

    entry_t ent_q [ENTRY_NUM];
    entry_t ent_d [ENTRY_NUM];

    logic [IDX_W-1:0] issue_idx;
    logic [IDX_W-1:0] alloc_idx;
    logic             any_ready;
    logic             any_free;
    logic             alloc_en;

    // Returns {valid, value}: an operand still waiting on a tag picks up a
    // matching broadcast, bus a taking precedence over bus b.
    function automatic logic [DATA_LEN:0] capture(input logic vld, input logic [DATA_LEN-1:0] val);
        logic [DATA_LEN:0] res;
        res = {vld, val};
        if (!vld) begin
            if (wb_we_a && wb_tag_a == val[RRF_SEL-1:0])
                res = {1'b1, wb_data_a};
            else if (wb_we_b && wb_tag_b == val[RRF_SEL-1:0])
                res = {1'b1, wb_data_b};
        end
        return res;
    endfunction

    // Descending scan so the lowest index wins both the issue and free searches.
    always_comb begin
        busyvec   = '0;
        issue_idx = '0;
        alloc_idx = '0;
        any_ready = 1'b0;
        any_free  = 1'b0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            busyvec[i] = ent_q[i].busy;
            if (ent_q[i].busy && ent_q[i].valid1 && ent_q[i].valid2) begin
                issue_idx = IDX_W'(i);
                any_ready = 1'b1;
            end
            if (!ent_q[i].busy) begin
                alloc_idx = IDX_W'(i);
                any_free  = 1'b1;
            end
        end
    end

    assign full     = ~any_free;
    assign issue    = any_ready & ~prmiss;
    assign alloc_en = we & any_free & ~prmiss;

    always_comb begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy) begin
                {ent_d[i].valid1, ent_d[i].src1} = capture(ent_q[i].valid1, ent_q[i].src1);
                {ent_d[i].valid2, ent_d[i].src2} = capture(ent_q[i].valid2, ent_q[i].src2);
            end
            if (issue && issue_idx == IDX_W'(i))
                ent_d[i].busy = 1'b0;
            // Kill is applied after wakeup so a killed entry always ends free.
            if (prmiss) begin
                if (ent_q[i].busy && ent_q[i].specbit && |(ent_q[i].spectag & killmask))
                    ent_d[i].busy = 1'b0;
            end else if (prsuccess && ent_q[i].busy && ent_q[i].spectag == spectagfix) begin
                ent_d[i].specbit = 1'b0;
            end
            if (alloc_en && alloc_idx == IDX_W'(i)) begin
                ent_d[i].busy    = 1'b1;
                {ent_d[i].valid1, ent_d[i].src1} = capture(valid1, src1);
                {ent_d[i].valid2, ent_d[i].src2} = capture(valid2, src2);
                ent_d[i].pc      = pc_in;
                ent_d[i].imm     = imm_in;
                ent_d[i].praddr  = praddr_in;
                ent_d[i].alu_op  = alu_op_in;
                ent_d[i].opcode  = opcode_in;
                ent_d[i].dstval  = dstval_in;
                ent_d[i].spectag = spectag_in;
                ent_d[i].specbit = specbit_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (reset) ent_q[i] <= '0;
            else       ent_q[i] <= ent_d[i];
        end
    end

    always_comb begin
        ex_src1    = '0;
        ex_src2    = '0;
        ex_pc      = '0;
        ex_imm     = '0;
        ex_praddr  = '0;
        ex_alu_op  = '0;
        ex_opcode  = '0;
        ex_dstval  = 1'b0;
        ex_spectag = '0;
        ex_specbit = 1'b0;
        if (issue) begin
            ex_src1    = ent_q[issue_idx].src1;
            ex_src2    = ent_q[issue_idx].src2;
            ex_pc      = ent_q[issue_idx].pc;
            ex_imm     = ent_q[issue_idx].imm;
            ex_praddr  = ent_q[issue_idx].praddr;
            ex_alu_op  = ent_q[issue_idx].alu_op;
            ex_opcode  = ent_q[issue_idx].opcode;
            ex_dstval  = ent_q[issue_idx].dstval;
            ex_spectag = ent_q[issue_idx].spectag;
            ex_specbit = ent_q[issue_idx].specbit;
        end
    end

endmodule

// File: tb/tb_rs_branch_queue.sv
// Bench for rs_branch_queue: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a behavioural model of the station.
module tb_rs_branch_queue;

    logic        clk = 1'b0;
    logic        reset, we, valid1, valid2, dstval_in, specbit_in;
    logic [31:0] src1, src2, pc_in, imm_in, praddr_in, wb_data_a, wb_data_b;
    logic [3:0]  alu_op_in;
    logic [6:0]  opcode_in;
    logic [4:0]  spectag_in, spectagfix, killmask;
    logic        wb_we_a, wb_we_b, prmiss, prsuccess;
    logic [5:0]  wb_tag_a, wb_tag_b;
    logic        issue, ex_dstval, ex_specbit, full;
    logic [31:0] ex_src1, ex_src2, ex_pc, ex_imm, ex_praddr;
    logic [3:0]  ex_alu_op, busyvec;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_spectag;

    int n_cmp = 0;
    int n_bad = 0;

    rs_branch_queue dut (
        .clk(clk), .reset(reset), .we(we), .src1(src1), .src2(src2),
        .valid1(valid1), .valid2(valid2), .pc_in(pc_in), .imm_in(imm_in),
        .praddr_in(praddr_in), .alu_op_in(alu_op_in), .opcode_in(opcode_in),
        .dstval_in(dstval_in), .spectag_in(spectag_in), .specbit_in(specbit_in),
        .wb_we_a(wb_we_a), .wb_we_b(wb_we_b), .wb_tag_a(wb_tag_a), .wb_tag_b(wb_tag_b),
        .wb_data_a(wb_data_a), .wb_data_b(wb_data_b), .prmiss(prmiss),
        .prsuccess(prsuccess), .spectagfix(spectagfix), .killmask(killmask),
        .issue(issue), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .ex_praddr(ex_praddr), .ex_alu_op(ex_alu_op),
        .ex_opcode(ex_opcode), .ex_dstval(ex_dstval), .ex_spectag(ex_spectag),
        .ex_specbit(ex_specbit), .full(full), .busyvec(busyvec)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        busy, v1, v2, dst, sb;
        bit [31:0] s1, s2, pc, imm, pra;
        bit [3:0]  op;
        bit [6:0]  opc;
        bit [4:0]  stag;
    } ment_t;

    ment_t m [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Operand pickup rule shared by waiting entries and incoming allocations.
    function automatic void pickup(input bit v, input bit [31:0] s, output bit vo, output bit [31:0] so);
        vo = v; so = s;
        if (!v && wb_we_a && wb_tag_a == s[5:0])      begin vo = 1; so = wb_data_a; end
        else if (!v && wb_we_b && wb_tag_b == s[5:0]) begin vo = 1; so = wb_data_b; end
    endfunction

    task automatic idle();
        reset = 0; we = 0; valid1 = 0; valid2 = 0; src1 = 0; src2 = 0;
        pc_in = 0; imm_in = 0; praddr_in = 0; alu_op_in = 0; opcode_in = 0;
        dstval_in = 0; spectag_in = 0; specbit_in = 0;
        wb_we_a = 0; wb_we_b = 0; wb_tag_a = 0; wb_tag_b = 0; wb_data_a = 0; wb_data_b = 0;
        prmiss = 0; prsuccess = 0; spectagfix = 0; killmask = 0;
    endtask

    task automatic alloc_set(input bit v1, input bit [31:0] s1, input bit v2, input bit [31:0] s2,
                             input bit sb, input bit [4:0] st);
        we = 1; valid1 = v1; src1 = s1; valid2 = v2; src2 = s2;
        specbit_in = sb; spectag_in = st;
        pc_in = $urandom; imm_in = $urandom; praddr_in = $urandom;
        alu_op_in = 4'($urandom); opcode_in = 7'($urandom); dstval_in = 1'($urandom);
    endtask

    // Compare all outputs at the falling edge, then advance the model across
    // the rising edge using the inputs that were applied this cycle.
    task automatic step();
        int    sel, fr;
        bit    exp_issue;
        bit [3:0] bv;
        ment_t n [4];
        ment_t e;
        @(negedge clk);
        sel = -1; fr = -1; bv = 0;
        for (int i = 0; i < 4; i++) begin
            bv[i] = m[i].busy;
            if (sel < 0 && m[i].busy && m[i].v1 && m[i].v2) sel = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        exp_issue = (sel >= 0) && !prmiss;
        e = '{default: 0};
        if (exp_issue) e = m[sel];
        chk("issue", issue, exp_issue);
        chk("busyvec", busyvec, bv);
        chk("full", full, fr < 0);
        chk("ex_src1", ex_src1, e.s1);
        chk("ex_src2", ex_src2, e.s2);
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_imm", ex_imm, e.imm);
        chk("ex_praddr", ex_praddr, e.pra);
        chk("ex_alu_op", ex_alu_op, e.op);
        chk("ex_opcode", ex_opcode, e.opc);
        chk("ex_dstval", ex_dstval, e.dst);
        chk("ex_spectag", ex_spectag, e.stag);
        chk("ex_specbit", ex_specbit, e.sb);

        n = m;
        for (int i = 0; i < 4; i++) begin
            if (m[i].busy) begin
                pickup(m[i].v1, m[i].s1, n[i].v1, n[i].s1);
                pickup(m[i].v2, m[i].s2, n[i].v2, n[i].s2);
            end
            if (prmiss && m[i].busy && m[i].sb && (m[i].stag & killmask) != 0) n[i].busy = 0;
            if (!prmiss && prsuccess && m[i].busy && m[i].stag == spectagfix) n[i].sb = 0;
        end
        if (exp_issue) n[sel].busy = 0;
        if (we && fr >= 0 && !prmiss) begin
            n[fr].busy = 1;
            pickup(valid1, src1, n[fr].v1, n[fr].s1);
            pickup(valid2, src2, n[fr].v2, n[fr].s2);
            n[fr].pc = pc_in; n[fr].imm = imm_in; n[fr].pra = praddr_in;
            n[fr].op = alu_op_in; n[fr].opc = opcode_in; n[fr].dst = dstval_in;
            n[fr].stag = spectag_in; n[fr].sb = specbit_in;
        end
        if (reset) n = '{default: '{default: 0}};
        @(posedge clk);
        #1;
        m = n;
        idle();
    endtask

    task automatic do_reset();
        idle(); reset = 1; step();
    endtask

    initial begin
        m = '{default: '{default: 0}};
        idle();
        reset = 1;
        step();
        chk("reset_busyvec", busyvec, 4'b0000);
        chk("reset_issue", issue, 1'b0);

        // Both operands ready: issues the cycle after allocation.
        alloc_set(1, 32'h10, 1, 32'h10, 0, 0); pc_in = 32'h100; imm_in = 32'h8; step();
        chk("t1_issue", issue, 1'b1);
        chk("t1_src1", ex_src1, 32'h10);
        chk("t1_pc", ex_pc, 32'h100);
        step();
        chk("t1_busyvec", busyvec, 4'b0000);

        // Waits on tag 5 until it is broadcast.
        alloc_set(0, 32'd5, 1, 32'h7, 0, 0); step();
        for (int k = 0; k < 3; k++) begin
            chk("t2_wait", issue, 1'b0);
            step();
        end
        wb_we_a = 1; wb_tag_a = 6'd5; wb_data_a = 32'h2A; step();
        chk("t2_issue", issue, 1'b1);
        chk("t2_src1", ex_src1, 32'h2A);
        step();

        // Fill, drop a fifth allocation, wake entry 2.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            alloc_set(0, 32'(k), 1, 32'h0, 0, 0); step();
        end
        chk("t3_full", full, 1'b1);
        chk("t3_busyvec", busyvec, 4'b1111);
        alloc_set(1, 32'h1, 1, 32'h1, 0, 0); step();
        chk("t3_drop", busyvec, 4'b1111);
        wb_we_b = 1; wb_tag_b = 6'd3; wb_data_b = 32'h33; step();
        chk("t3_issue", issue, 1'b1);
        chk("t3_src1", ex_src1, 32'h33);
        step();
        chk("t3_notfull", full, 1'b0);
        chk("t3_busyvec2", busyvec, 4'b1011);

        // Two ready together: lowest index first.
        do_reset();
        alloc_set(0, 32'd9, 1, 32'hA, 0, 0); step();
        alloc_set(0, 32'd9, 1, 32'hB, 0, 0); step();
        wb_we_a = 1; wb_tag_a = 6'd9; wb_data_a = 32'h99; step();
        chk("t4_first", ex_src2, 32'hA);
        step();
        chk("t4_second", ex_src2, 32'hB);
        step();

        // Selective kill on misprediction.
        do_reset();
        alloc_set(0, 32'd1, 1, 32'h0, 0, 5'b00000); step();
        alloc_set(0, 32'd1, 1, 32'h0, 1, 5'b00100); step();
        alloc_set(0, 32'd1, 1, 32'h0, 1, 5'b01000); step();
        prmiss = 1; killmask = 5'b00100;
        #1;
        chk("t5_noissue", issue, 1'b0);
        step();
        chk("t5_busyvec", busyvec, 4'b0101);

        // Resolved-correct entry survives a later kill; then reset mid-run.
        do_reset();
        alloc_set(0, 32'd2, 1, 32'h0, 1, 5'b00010); step();
        prsuccess = 1; spectagfix = 5'b00010; step();
        prmiss = 1; killmask = 5'b00010; step();
        chk("t6_kept", busyvec, 4'b0001);
        reset = 1; we = 1; step();
        chk("t6_reset", busyvec, 4'b0000);

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            reset      = ($urandom_range(0, 149) == 0);
            we         = ($urandom_range(0, 2) != 0);
            valid1     = ($urandom_range(0, 2) != 0);
            valid2     = ($urandom_range(0, 2) != 0);
            src1       = valid1 ? $urandom : $urandom_range(0, 7);
            src2       = valid2 ? $urandom : $urandom_range(0, 7);
            pc_in      = $urandom; imm_in = $urandom; praddr_in = $urandom;
            alu_op_in  = 4'($urandom); opcode_in = 7'($urandom); dstval_in = 1'($urandom);
            spectag_in = 5'(1) << $urandom_range(0, 4);
            specbit_in = 1'($urandom);
            wb_we_a    = 1'($urandom); wb_tag_a = 6'($urandom_range(0, 7)); wb_data_a = $urandom;
            wb_we_b    = 1'($urandom); wb_tag_b = 6'($urandom_range(0, 7)); wb_data_b = $urandom;
            prmiss     = ($urandom_range(0, 11) == 0);
            prsuccess  = ($urandom_range(0, 5) == 0);
            spectagfix = 5'(1) << $urandom_range(0, 4);
            killmask   = 5'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rs_branch_queue.md
Name: rs_branch_queue

Overview:
Four-entry reservation station for the branch execution unit.
- Holds renamed branch/jump micro-ops until both source operands are available.
- Captures operands from two writeback broadcast buses.
- Issues one ready entry per cycle to the branch execution unit.
- On branch resolution, kills wrong-path entries or clears their speculative bits.

Parameters:
DATA_LEN, 32, operand/immediate width
ADDR_LEN, 32, PC/predicted-address width
RRF_SEL, 6, rename-register tag width
SPECTAG_LEN, 5, one-hot speculative tag width
ALU_OP_WIDTH, 4, comparator op width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
we  in  1  allocate one entry this cycle
src1 / src2  in  DATA_LEN each  operand value, or RRF tag in the low RRF_SEL bits when the matching valid bit is 0
valid1 / valid2  in  1 each  operand already available
pc_in / imm_in / praddr_in  in  ADDR_LEN / DATA_LEN / ADDR_LEN  instruction fields
alu_op_in / opcode_in / dstval_in  in  ALU_OP_WIDTH / 7 / 1  instruction fields
spectag_in / specbit_in  in  SPECTAG_LEN / 1  speculative tag and speculative flag
wb_we_a, wb_we_b  in  1 each  broadcast valid
wb_tag_a, wb_tag_b  in  RRF_SEL each  broadcast tag
wb_data_a, wb_data_b  in  DATA_LEN each  broadcast value
prmiss / prsuccess  in  1 each  branch resolution from the branch unit
spectagfix  in  SPECTAG_LEN  one-hot tag of the resolving branch
killmask  in  SPECTAG_LEN  tags dependent on the mispredicted branch
issue  out  1  ex_* outputs valid this cycle
ex_src1 / ex_src2 / pc / imm / praddr / alu_op / opcode / dstval / spectag / specbit  out  matching widths  fields of the selected entry
full  out  1  all 4 entries busy
busyvec  out  4  per-entry busy bits

Behaviour:
- All state is registered on the posedge of clk.
- Reset: busy=0, valid bits=0, specbit=0 for all entries. Consequently issue=0, full=0, busyvec=0, and all ex_* outputs are 0 (outputs are forced to 0 when issue=0).
- Allocation:
  - When we=1 and not full, the lowest-index free entry is written. It becomes busy and visible next cycle.
  - If full or prmiss=1, a we=1 request is dropped. Upstream must not assert we when full.
- Wakeup:
  - Each cycle, every busy entry with valid_i=0 and (wb_we_x && wb_tag_x == tag_i) captures wb_data_x and sets valid_i.
  - If both buses match the same operand, bus a wins.
- Same-cycle forwarding on allocation: an incoming operand with valid=0 whose tag matches an active broadcast in the allocation cycle is stored as valid with the broadcast data.
- Ready: busy & valid1 & valid2, evaluated on registered state, so a wakeup becomes issuable the following cycle.
- Issue:
  - Combinational select of the lowest-index ready entry.
  - issue = any_ready & ~prmiss.
  - The issued entry's busy bit clears at the next edge.
  - Latency from allocation with both operands valid to issue is 1 cycle.
  - The branch unit always accepts, so there is no backpressure.
- prmiss=1: at the next edge, every busy entry with specbit=1 and (spectag & killmask)!=0 is freed. Non-speculative entries and entries with non-matching tags are retained.
- prsuccess=1: at the next edge, every busy entry with spectag==spectagfix has its specbit cleared.
- Simultaneous prmiss and prsuccess: prmiss has priority and prsuccess is ignored.
- Kill and wakeup of the same entry in one cycle: kill wins, and the entry ends free.
- Free plus allocate in one cycle: the freed slot is not reusable until the next cycle. Allocation uses the pre-edge busy vector.
- Reset asserted mid-operation clears all entries regardless of other inputs.

Test Plan:
1. Reset, then allocate with valid1=valid2=1, src1=0x10, src2=0x10, pc=0x100, imm=8 -> next cycle issue=1, ex_src1=0x10, pc=0x100; following cycle busyvec=0.
2. Allocate with valid1=0, tag 5; after 3 cycles broadcast wb_we_a=1, wb_tag_a=5, wb_data_a=0x2A -> issue is 0 until the cycle after the broadcast, then issue=1 with ex_src1=0x2A.
3. Allocate 4 non-ready entries -> full=1, busyvec=4'b1111; a 5th we is dropped; wake entry 2 -> entry 2 issues, then full=0.
4. Entries 0 and 1 both ready -> entry 0 issues first and entry 1 on the next cycle.
5. Entry 0 non-speculative, entry 1 specbit=1 spectag=5'b00100, entry 2 specbit=1 spectag=5'b01000; prmiss=1 with killmask=5'b00100 -> busyvec=4'b0101 and issue=0 during the prmiss cycle.
6. Entry with specbit=1 spectag=5'b00010; prsuccess=1 with spectagfix=5'b00010 -> specbit=0, so a later prmiss with killmask=5'b00010 does not free it. Assert reset mid-test -> busyvec=0.
